// File: rtl/riscv_if_parcel_queue_pkg.sv
// riscv_if_parcel_queue_pkg: shared constants and helpers for the IF parcel queue.
package riscv_if_parcel_queue_pkg;
  localparam int PARCEL_SIZE = 16;
  function automatic logic is_rvc(input logic [1:0] lsb);
    return lsb != 2'b11;
  endfunction
endpackage

// File: rtl/riscv_if_parcel_queue_if.sv
// riscv_if_parcel_queue_if: fetch-response, request-throttle and IF-instruction signals of the parcel queue.
interface riscv_if_parcel_queue_if #(parameter int XLEN = 32);
  localparam int PPW = XLEN / 16;
  logic flush_i;
  logic [XLEN-1:0] parcel_i;
  logic [XLEN-1:0] parcel_pc_i;
  logic [PPW-1:0] parcel_valid_i;
  logic parcel_error_i;
  logic parcel_misaligned_i;
  logic req_ack_i;
  logic rsp_i;
  logic req_o;
  logic instr_valid_o;
  logic instr_ready_i;
  logic [31:0] instr_o;
  logic [XLEN-1:0] instr_pc_o;
  logic instr_rvc_o;
  logic instr_error_o;
  logic instr_misaligned_o;
  modport master (
    output flush_i, parcel_i, parcel_pc_i, parcel_valid_i, parcel_error_i, parcel_misaligned_i,
    output req_ack_i, rsp_i, instr_ready_i,
    input req_o, instr_valid_o, instr_o, instr_pc_o, instr_rvc_o, instr_error_o, instr_misaligned_o
  );
  modport slave (
    input flush_i, parcel_i, parcel_pc_i, parcel_valid_i, parcel_error_i, parcel_misaligned_i,
    input req_ack_i, rsp_i, instr_ready_i,
    output req_o, instr_valid_o, instr_o, instr_pc_o, instr_rvc_o, instr_error_o, instr_misaligned_o
  );
endinterface

// File: rtl/riscv_if_parcel_queue.sv
// riscv_if_parcel_queue: compacts fetched parcels into a circular buffer and hands out aligned 16/32-bit instructions.
module riscv_if_parcel_queue
  import riscv_if_parcel_queue_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int HAS_RVC  = 0,
  parameter int QDEPTH   = 8,
  parameter int INFLIGHT = 2
) (
  input logic clk_i,
  input logic rst_ni,
  riscv_if_parcel_queue_if.slave q
);
  localparam int PPW = XLEN / PARCEL_SIZE;
  localparam int AW  = $clog2(QDEPTH);
  localparam int CW  = AW + 1;
  localparam int OW  = $clog2(INFLIGHT) + 1;
  typedef struct packed {
    logic [PARCEL_SIZE-1:0] data;
    logic [XLEN-1:0]        pc;
    logic                   err;
    logic                   mis;
  } parcel_t;
  parcel_t mem [QDEPTH];
  logic [AW-1:0] rd_q, wr_q, rd1, lo;
  logic [CW-1:0] cnt_q, n_push, n_pop, need;
  logic [OW-1:0] out_q;
  logic any, push, rvc, full, two, pop;
  always_comb begin
    lo = '0;
    for (int i = PPW - 1; i >= 0; i--) if (q.parcel_valid_i[i]) lo = AW'(i);
    any = |q.parcel_valid_i;
    push = !q.flush_i && (any || q.parcel_error_i);
    n_push = !push ? '0 : any ? CW'(PPW) - CW'(lo) : CW'(1);
    rd1 = rd_q + 1'b1;
    rvc = (HAS_RVC != 0) && is_rvc(mem[rd_q].data[1:0]);
    need = rvc ? CW'(1) : CW'(2);
    full = cnt_q >= need;
    two = !rvc && full;
    // an errored head is delivered even when its partner parcel never arrives
    q.instr_valid_o = (cnt_q != '0) && (full || mem[rd_q].err);
    pop = q.instr_valid_o && q.instr_ready_i && !q.flush_i;
    n_pop = !pop ? '0 : full ? need : cnt_q;
    q.instr_o = !q.instr_valid_o ? '0 : rvc ? {16'h0, mem[rd_q].data} : {mem[rd1].data, mem[rd_q].data};
    q.instr_pc_o = q.instr_valid_o ? mem[rd_q].pc : '0;
    q.instr_rvc_o = q.instr_valid_o && rvc;
    q.instr_error_o = q.instr_valid_o && (mem[rd_q].err || (two && mem[rd1].err));
    q.instr_misaligned_o = q.instr_valid_o && (mem[rd_q].mis || (two && mem[rd1].mis));
    // every outstanding response must find PPW free parcels
    q.req_o = rst_ni && !q.flush_i && (QDEPTH - 32'(cnt_q) >= (32'(out_q) + 1) * PPW) && (32'(out_q) < INFLIGHT);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      out_q <= out_q + OW'(q.req_ack_i) - OW'(q.rsp_i);
      if (q.flush_i) begin
        rd_q <= '0;
        wr_q <= '0;
        cnt_q <= '0;
      end else begin
        rd_q <= rd_q + AW'(n_pop);
        wr_q <= wr_q + AW'(n_push);
        cnt_q <= cnt_q + n_push - n_pop;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      if (any) begin
        for (int i = 0; i < PPW; i++)
          if (q.parcel_valid_i[i])
            mem[wr_q + AW'(i) - lo] <= '{data: q.parcel_i[PARCEL_SIZE*i +: PARCEL_SIZE],
                                       pc: q.parcel_pc_i + XLEN'({AW'(i) - lo, 1'b0}),
                                       err: q.parcel_error_i, mis: q.parcel_misaligned_i};
      end else begin
        mem[wr_q] <= '{data: '0, pc: q.parcel_pc_i, err: 1'b1, mis: q.parcel_misaligned_i};
      end
    end
  end
  overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && (32'(n_push) > QDEPTH - 32'(cnt_q))))
    else $error("parcel queue overflow");
endmodule

// File: tb/tb_riscv_if_parcel_queue.sv
// tb_riscv_if_parcel_queue: directed and randomized checks of the parcel queue against a parcel-list reference model.
module tb_riscv_if_parcel_queue;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;
  riscv_if_parcel_queue_if #(.XLEN(32)) bus ();
  riscv_if_parcel_queue #(.XLEN(32), .HAS_RVC(1), .QDEPTH(8), .INFLIGHT(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .q(bus)
  );
  typedef struct {
    logic [15:0] d;
    logic [31:0] pc;
    logic e;
    logic m;
  } p_t;
  localparam logic [68:0] TRUNC_MASK = ~(69'hFFFF << 16);
  p_t mq[$];
  int mo = 0;
  int pend = 0;
  int compared = 0;
  int mismatched = 0;
  logic [31:0] fpc = 32'h1000;
  logic [68:0] obs;
  assign obs = {bus.req_o, bus.instr_valid_o, bus.instr_rvc_o, bus.instr_error_o,
                bus.instr_misaligned_o, bus.instr_pc_o, bus.instr_o};

  function automatic logic [68:0] expv();
    logic req, full, e, m;
    int need, take;
    logic [31:0] ins;
    req = rst_ni && !bus.flush_i && (8 - mq.size() >= (mo + 1) * 2) && mo < 2;
    if (mq.size() == 0) return {req, 68'h0};
    need = (mq[0].d[1:0] == 2'b11) ? 2 : 1;
    full = mq.size() >= need;
    if (!full && !mq[0].e) return {req, 68'h0};
    take = full ? need : mq.size();
    e = 1'b0;
    m = 1'b0;
    for (int i = 0; i < take; i++) begin
      e |= mq[i].e;
      m |= mq[i].m;
    end
    ins = (need == 1) ? {16'h0, mq[0].d} : {full ? mq[1].d : 16'h0, mq[0].d};
    return {req, 1'b1, need == 1, e, m, mq[0].pc, ins};
  endfunction

  task automatic model_edge();
    logic [68:0] x;
    int take, k;
    if (!rst_ni) begin
      mq.delete();
      mo = 0;
      return;
    end
    x = expv();
    if (!bus.flush_i && x[67] && bus.instr_ready_i) begin
      take = x[66] ? 1 : (mq.size() >= 2 ? 2 : 1);
      repeat (take) void'(mq.pop_front());
    end
    if (bus.flush_i) mq.delete();
    else if (|bus.parcel_valid_i) begin
      k = 0;
      for (int i = 0; i < 2; i++)
        if (bus.parcel_valid_i[i]) begin
          mq.push_back('{d: bus.parcel_i[16*i +: 16], pc: bus.parcel_pc_i + 32'(2 * k),
                         e: bus.parcel_error_i, m: bus.parcel_misaligned_i});
          k++;
        end
    end else if (bus.parcel_error_i)
      mq.push_back('{d: 16'h0, pc: bus.parcel_pc_i, e: 1'b1, m: bus.parcel_misaligned_i});
    mo += int'(bus.req_ack_i) - int'(bus.rsp_i);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    bus.flush_i = 1'b0;
    bus.parcel_i = '0;
    bus.parcel_pc_i = '0;
    bus.parcel_valid_i = '0;
    bus.parcel_error_i = 1'b0;
    bus.parcel_misaligned_i = 1'b0;
    bus.req_ack_i = 1'b0;
    bus.rsp_i = 1'b0;
  endtask

  task automatic drive(input logic [31:0] d, input logic [31:0] pc, input logic [1:0] v,
                       input logic e, input logic m);
    bus.parcel_i = d;
    bus.parcel_pc_i = pc;
    bus.parcel_valid_i = v;
    bus.parcel_error_i = e;
    bus.parcel_misaligned_i = m;
  endtask

  task automatic fetch_cycle(input logic fl, input logic rrand, input logic rdy, input logic ack_ok);
    logic rsp, mis;
    logic [68:0] x;
    rsp = pend > 0 && $urandom_range(0, 2) != 0;
    mis = $urandom_range(0, 7) == 0;
    idle();
    if (rsp && fl && $urandom_range(0, 14) == 0) drive(32'h0, fpc, 2'b00, 1'b1, mis);
    else if (rsp) drive($urandom, fpc, ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11, 1'b0, mis);
    if (rsp) fpc += 4;
    bus.flush_i = fl && $urandom_range(0, 24) == 0;
    bus.instr_ready_i = rrand ? 1'($urandom_range(0, 1)) : rdy;
    bus.rsp_i = rsp;
    x = expv();
    bus.req_ack_i = ack_ok && x[68] && $urandom_range(0, 1) == 1;
    pend += int'(bus.req_ack_i) - int'(rsp);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_i);
    #1;
    compared++;
    if (obs !== 69'h0) begin
      mismatched++;
      $display("FAIL reset_outputs got=%h exp=%h", obs, 69'h0);
    end
    @(negedge clk_i) rst_ni = 1'b1;
    tick();
    compared++;
    if (obs !== expv() || obs !== {1'b1, 68'h0}) begin
      mismatched++;
      $display("FAIL after_reset got=%h exp=%h", obs, expv());
    end
  endtask

  task automatic test_32bit();
    bus.instr_ready_i = 1'b0;
    drive(32'h00000013, 32'h100, 2'b11, 1'b0, 1'b0);
    tick();
    compared++;
    if (obs !== expv() || bus.instr_o !== 32'h00000013 || bus.instr_pc_o !== 32'h100 || bus.instr_valid_o !== 1'b1) begin
      mismatched++;
      $display("FAIL w32_first got=%h exp=%h", obs, expv());
    end
    drive(32'h00100093, 32'h104, 2'b11, 1'b0, 1'b0);
    bus.instr_ready_i = 1'b1;
    tick();
    compared++;
    if (obs !== expv() || bus.instr_o !== 32'h00100093 || bus.instr_pc_o !== 32'h104 || bus.instr_rvc_o !== 1'b0) begin
      mismatched++;
      $display("FAIL w32_second got=%h exp=%h", obs, expv());
    end
    idle();
    tick();
    compared++;
    if (obs !== expv() || bus.instr_valid_o !== 1'b0) begin
      mismatched++;
      $display("FAIL w32_drain got=%h exp=%h", obs, expv());
    end
  endtask

  task automatic test_rvc();
    bus.instr_ready_i = 1'b0;
    drive(32'h00134501, 32'h200, 2'b11, 1'b0, 1'b0);
    tick();
    compared++;
    if (obs !== expv() || bus.instr_o !== 32'h4501 || bus.instr_pc_o !== 32'h200 || bus.instr_rvc_o !== 1'b1) begin
      mismatched++;
      $display("FAIL rvc_head got=%h exp=%h", obs, expv());
    end
    idle();
    bus.instr_ready_i = 1'b1;
    tick();
    compared++;
    if (obs !== expv() || bus.instr_valid_o !== 1'b0) begin
      mismatched++;
      $display("FAIL rvc_partial got=%h exp=%h", obs, expv());
    end
    drive(32'hABCD0000, 32'h204, 2'b11, 1'b0, 1'b0);
    bus.instr_ready_i = 1'b0;
    tick();
    compared++;
    if (obs !== expv() || bus.instr_o !== 32'h00000013 || bus.instr_pc_o !== 32'h202 || bus.instr_rvc_o !== 1'b0) begin
      mismatched++;
      $display("FAIL rvc_span got=%h exp=%h", obs, expv());
    end
    idle();
    bus.instr_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      compared++;
      if (obs !== expv()) begin
        mismatched++;
        $display("FAIL rvc_drain c=%0d got=%h exp=%h", c, obs, expv());
      end
    end
  endtask

  task automatic test_wrap();
    idle();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    bus.instr_ready_i = 1'b1;
    for (int w = 0; w < 4; w++) begin
      drive(32'h00010001, 32'h300 + 32'(4 * w), (w == 3) ? 2'b10 : 2'b11, 1'b0, 1'b0);
      tick();
      compared++;
      if (obs !== expv()) begin
        mismatched++;
        $display("FAIL wrap_fill w=%0d got=%h exp=%h", w, obs, expv());
      end
    end
    idle();
    for (int c = 0; c < 6; c++) begin
      tick();
      compared++;
      if (obs !== expv()) begin
        mismatched++;
        $display("FAIL wrap_empty c=%0d got=%h exp=%h", c, obs, expv());
      end
    end
    bus.instr_ready_i = 1'b0;
    drive(32'hABCD0013, 32'h400, 2'b11, 1'b0, 1'b1);
    tick();
    compared++;
    if (obs !== expv() || bus.instr_o !== 32'hABCD0013 || bus.instr_pc_o !== 32'h400 || bus.instr_misaligned_o !== 1'b1) begin
      mismatched++;
      $display("FAIL wrap_span got=%h exp=%h", obs, expv());
    end
    idle();
    bus.instr_ready_i = 1'b1;
    tick();
    compared++;
    if (obs !== expv() || bus.instr_valid_o !== 1'b0) begin
      mismatched++;
      $display("FAIL wrap_pop got=%h exp=%h", obs, expv());
    end
  endtask

  task automatic test_bus_error();
    bus.instr_ready_i = 1'b0;
    drive(32'h0, 32'h300, 2'b00, 1'b1, 1'b0);
    tick();
    compared++;
    if (obs !== expv() || bus.instr_valid_o !== 1'b1 || bus.instr_error_o !== 1'b1 || bus.instr_pc_o !== 32'h300) begin
      mismatched++;
      $display("FAIL err_empty_mask got=%h exp=%h", obs, expv());
    end
    idle();
    bus.instr_ready_i = 1'b1;
    tick();
    compared++;
    if (obs !== expv() || bus.instr_valid_o !== 1'b0) begin
      mismatched++;
      $display("FAIL err_pop got=%h exp=%h", obs, expv());
    end
    bus.instr_ready_i = 1'b0;
    drive(32'h00130000, 32'h310, 2'b10, 1'b1, 1'b1);
    tick();
    compared++;
    if ((obs & TRUNC_MASK) !== (expv() & TRUNC_MASK) || bus.instr_error_o !== 1'b1 || bus.instr_rvc_o !== 1'b0 || bus.instr_pc_o !== 32'h310) begin
      mismatched++;
      $display("FAIL err_truncated got=%h exp=%h", obs, expv());
    end
    idle();
    bus.instr_ready_i = 1'b1;
    tick();
    compared++;
    if (obs !== expv() || bus.instr_valid_o !== 1'b0) begin
      mismatched++;
      $display("FAIL err_trunc_pop got=%h exp=%h", obs, expv());
    end
  endtask

  task automatic test_flush();
    bus.instr_ready_i = 1'b0;
    drive(32'h00010001, 32'h500, 2'b11, 1'b0, 1'b0);
    bus.req_ack_i = 1'b1;
    tick();
    compared++;
    if (obs !== expv()) begin
      mismatched++;
      $display("FAIL flush_prep got=%h exp=%h", obs, expv());
    end
    bus.req_ack_i = 1'b0;
    drive(32'h00010001, 32'h504, 2'b11, 1'b0, 1'b0);
    bus.flush_i = 1'b1;
    bus.instr_ready_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    #1;
    compared++;
    if (obs !== expv() || bus.instr_valid_o !== 1'b0 || bus.instr_o !== 32'h0) begin
      mismatched++;
      $display("FAIL flush_same_cycle got=%h exp=%h", obs, expv());
    end
    idle();
    bus.req_ack_i = 1'b1;
    tick();
    compared++;
    if (obs !== expv() || bus.req_o !== 1'b0) begin
      mismatched++;
      $display("FAIL flush_outstanding got=%h exp=%h", obs, expv());
    end
    for (int r = 0; r < 2; r++) begin
      idle();
      drive(32'h00010001, 32'h600 + 32'(4 * r), 2'b11, 1'b0, 1'b0);
      bus.rsp_i = 1'b1;
      tick();
      compared++;
      if (obs !== expv()) begin
        mismatched++;
        $display("FAIL flush_rsp r=%0d got=%h exp=%h", r, obs, expv());
      end
    end
    idle();
    for (int c = 0; c < 4; c++) begin
      tick();
      compared++;
      if (obs !== expv()) begin
        mismatched++;
        $display("FAIL flush_drain c=%0d got=%h exp=%h", c, obs, expv());
      end
    end
  endtask

  task automatic test_throttle();
    logic saw_low = 1'b0;
    for (int c = 0; c < 60; c++) begin
      fetch_cycle(1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      if (!bus.req_o) saw_low = 1'b1;
      compared++;
      if (obs !== expv()) begin
        mismatched++;
        $display("FAIL throttle c=%0d got=%h exp=%h", c, obs, expv());
      end
    end
    compared++;
    if (saw_low !== 1'b1) begin
      mismatched++;
      $display("FAIL throttle_deassert got=%0b exp=1", saw_low);
    end
    for (int c = 0; c < 100 && (pend > 0 || mq.size() > 0); c++) begin
      fetch_cycle(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      compared++;
      if (obs !== expv()) begin
        mismatched++;
        $display("FAIL throttle_drain c=%0d got=%h exp=%h", c, obs, expv());
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      fetch_cycle(1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      compared++;
      if (obs !== expv()) begin
        mismatched++;
        $display("FAIL random c=%0d got=%h exp=%h", c, obs, expv());
      end
    end
    for (int c = 0; c < 100 && (pend > 0 || mq.size() > 0); c++) begin
      fetch_cycle(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      compared++;
      if (obs !== expv()) begin
        mismatched++;
        $display("FAIL random_drain c=%0d got=%h exp=%h", c, obs, expv());
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    bus.instr_ready_i = 1'b0;
    drive(32'h00010001, 32'h700, 2'b11, 1'b0, 1'b0);
    bus.req_ack_i = 1'b1;
    tick();
    idle();
    rst_ni = 1'b0;
    #1;
    compared++;
    if (obs !== 69'h0) begin
      mismatched++;
      $display("FAIL reset_mid got=%h exp=%h", obs, 69'h0);
    end
    mq.delete();
    mo = 0;
    @(negedge clk_i) rst_ni = 1'b1;
    tick();
    compared++;
    if (obs !== expv() || bus.instr_valid_o !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release got=%h exp=%h", obs, expv());
    end
    drive(32'h00010001, 32'h800, 2'b11, 1'b0, 1'b0);
    tick();
    compared++;
    if (obs !== expv() || bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h800) begin
      mismatched++;
      $display("FAIL reset_new_push got=%h exp=%h", obs, expv());
    end
    idle();
  endtask

  initial begin
    idle();
    bus.instr_ready_i = 1'b0;
    test_reset();
    test_32bit();
    test_rvc();
    test_wrap();
    test_bus_error();
    test_flush();
    test_throttle();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
